// File: rtl/pong_state_reader.sv
// pong_state_reader: steps a multiplexed game core through its four state fields
// and publishes each completed frame over a valid/ready handshake.
`default_nettype none

module pong_state_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_run,
  input  logic [3:0] half_period,
  input  logic [7:0] game_bus,
  input  logic       frame_ready,
  output logic       game_step,
  output logic [1:0] game_sel,
  output logic       busy,
  output logic       frame_valid,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic [7:0] left_y,
  output logic [7:0] right_y,
  output logic [7:0] frame_count,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [1:0] field, field_nx;
  logic [3:0] phase, phase_nx;
  logic [3:0] h_lat, h_nx;
  logic [3:0] h_in;
  logic       phase_last;
  logic       capture;
  logic       publish;
  logic [7:0] shadow_x, shadow_y, shadow_l;

  assign h_in       = (half_period == 4'd0) ? 4'd1 : half_period;
  assign phase_last = (phase == (h_lat - 4'd1));

  assign game_step = (state == S_HIGH);
  assign busy      = (state != S_IDLE);
  assign game_sel  = field;

  always_comb begin
    state_nx = state;
    field_nx = field;
    phase_nx = phase;
    h_nx     = h_lat;
    capture  = 1'b0;
    publish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start || auto_run) begin
          state_nx = S_SETUP;
          field_nx = 2'd0;
          phase_nx = 4'd0;
          h_nx     = h_in;
        end
      end
      S_SETUP: begin
        if (phase_last) begin
          state_nx = S_HIGH;
          phase_nx = 4'd0;
        end else begin
          phase_nx = phase + 4'd1;
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          state_nx = S_LOW;
          phase_nx = 4'd0;
        end else begin
          phase_nx = phase + 4'd1;
        end
      end
      S_LOW: begin
        if (phase_last) begin
          capture  = 1'b1;
          phase_nx = 4'd0;
          if (field == 2'd3) begin
            publish  = 1'b1;
            state_nx = S_IDLE;
            field_nx = 2'd0;
          end else begin
            state_nx = S_SETUP;
            field_nx = field + 2'd1;
          end
        end else begin
          phase_nx = phase + 4'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      field       <= 2'd0;
      phase       <= 4'd0;
      h_lat       <= 4'd0;
      shadow_x    <= 8'd0;
      shadow_y    <= 8'd0;
      shadow_l    <= 8'd0;
      ball_x      <= 8'd0;
      ball_y      <= 8'd0;
      left_y      <= 8'd0;
      right_y     <= 8'd0;
      frame_valid <= 1'b0;
      frame_count <= 8'd0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nx;
      field <= field_nx;
      phase <= phase_nx;
      h_lat <= h_nx;
      if (capture) begin
        case (field)
          2'd0:    shadow_x <= game_bus;
          2'd1:    shadow_y <= game_bus;
          2'd2:    shadow_l <= game_bus;
          default: ;
        endcase
      end
      // The last field goes straight from the bus so all four outputs update together.
      if (publish) begin
        ball_x      <= shadow_x;
        ball_y      <= shadow_y;
        left_y      <= shadow_l;
        right_y     <= game_bus;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 8'd1;
        if (frame_valid && !frame_ready) overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
